// File: rtl/maple_rx_decoder.sv
// Maple Bus receiver: decodes the SDCKA/SDCKB pair into a byte-wide AXI-Stream packet
// with tlast on the final byte, plus receiving and error-pulse status outputs.
module maple_rx_decoder #(
    parameter int unsigned C_SYNC_STAGES    = 2,
    parameter int unsigned C_TIMEOUT_WIDTH  = 16,
    parameter int unsigned C_TIMEOUT_CYCLES = 10000
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       sdcka,
    input  logic       sdckb,
    input  logic       enable,
    output logic       m_axis_tvalid,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tstrb,
    output logic       m_axis_tkeep,
    output logic       m_axis_tlast,
    input  logic       m_axis_tready,
    output logic       receiving,
    output logic       err_framing,
    output logic       err_timeout,
    output logic       err_overflow
);

    localparam int unsigned BYTE_W = 8;
    localparam logic [C_TIMEOUT_WIDTH-1:0] TMO_LAST = C_TIMEOUT_WIDTH'(C_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_END, S_ABORT} state_e;

    state_e                     state_q, state_d;
    logic [C_SYNC_STAGES-1:0]   a_sync_q, b_sync_q;
    logic                       a_lvl_q, b_lvl_q;
    logic                       a_rise_q, a_fall_q, b_rise_q, b_fall_q;
    logic [2:0]                 pcnt_q, pcnt_d;
    logic [1:0]                 ecnt_q, ecnt_d;
    logic [2:0]                 bitcnt_q, bitcnt_d;
    logic                       phase_b_q, phase_b_d;
    logic [BYTE_W-1:0]          shift_q, shift_d;
    logic [C_TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
    logic [BYTE_W-1:0]          hold_q, hold_d;
    logic                       hold_vld_q, hold_vld_d;
    logic                       tvalid_q, tvalid_d;
    logic [BYTE_W-1:0]          tdata_q, tdata_d;
    logic                       tlast_q, tlast_d;
    logic                       rcv_q;
    logic                       err_framing_q, err_framing_d;
    logic                       err_timeout_q, err_timeout_d;
    logic                       err_overflow_q, err_overflow_d;
    logic                       sample_en, sample_bit;
    logic                       any_edge, counting, tmo_hit, out_free;

    // Synchroniser chain followed by the edge register; lines idle high.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            a_sync_q <= '1;
            b_sync_q <= '1;
            a_lvl_q  <= 1'b1;
            b_lvl_q  <= 1'b1;
            a_rise_q <= 1'b0;
            a_fall_q <= 1'b0;
            b_rise_q <= 1'b0;
            b_fall_q <= 1'b0;
        end else begin
            a_sync_q <= {a_sync_q[C_SYNC_STAGES-2:0], sdcka};
            b_sync_q <= {b_sync_q[C_SYNC_STAGES-2:0], sdckb};
            a_lvl_q  <= a_sync_q[C_SYNC_STAGES-1];
            b_lvl_q  <= b_sync_q[C_SYNC_STAGES-1];
            a_rise_q <= ~a_lvl_q &  a_sync_q[C_SYNC_STAGES-1];
            a_fall_q <=  a_lvl_q & ~a_sync_q[C_SYNC_STAGES-1];
            b_rise_q <= ~b_lvl_q &  b_sync_q[C_SYNC_STAGES-1];
            b_fall_q <=  b_lvl_q & ~b_sync_q[C_SYNC_STAGES-1];
        end
    end

    assign any_edge = a_rise_q | a_fall_q | b_rise_q | b_fall_q;
    assign counting = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_END);
    assign tmo_hit  = counting && !any_edge && (tmo_q == TMO_LAST);
    assign out_free = !tvalid_q || m_axis_tready;

    // Next-state, byte buffering and output-register logic.
    always_comb begin
        state_d        = state_q;
        pcnt_d         = pcnt_q;
        ecnt_d         = ecnt_q;
        bitcnt_d       = bitcnt_q;
        phase_b_d      = phase_b_q;
        shift_d        = shift_q;
        hold_d         = hold_q;
        hold_vld_d     = hold_vld_q;
        tvalid_d       = tvalid_q & ~m_axis_tready;
        tdata_d        = tdata_q;
        tlast_d        = tlast_q;
        err_framing_d  = 1'b0;
        err_timeout_d  = 1'b0;
        err_overflow_d = 1'b0;
        sample_en      = 1'b0;
        sample_bit     = 1'b0;
        tmo_d          = (any_edge || !counting) ? '0 : tmo_q + C_TIMEOUT_WIDTH'(1);

        unique case (state_q)
            S_IDLE: begin
                if (enable && a_fall_q && b_lvl_q) begin
                    state_d = S_START;
                    pcnt_d  = '0;
                end
            end
            S_START: begin
                if (!enable) begin
                    state_d = S_ABORT;
                end else if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_ABORT;
                end else if (a_rise_q) begin
                    if (pcnt_q == 3'd4) begin
                        state_d   = S_DATA;
                        phase_b_d = 1'b0;
                        bitcnt_d  = '0;
                    end else begin
                        err_framing_d = 1'b1;
                        state_d       = S_IDLE;
                    end
                end else if (b_fall_q && !a_lvl_q && (pcnt_q != 3'd7)) begin
                    pcnt_d = pcnt_q + 3'd1;
                end
            end
            S_DATA: begin
                if (!enable) begin
                    state_d = S_ABORT;
                end else if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_ABORT;
                end else if (a_fall_q && b_fall_q) begin
                    err_framing_d = 1'b1;
                    state_d       = S_ABORT;
                end else if (!phase_b_q) begin
                    if (a_fall_q) begin
                        sample_en  = 1'b1;
                        sample_bit = b_lvl_q;
                    end else if (b_fall_q) begin
                        if ((bitcnt_q == 3'd0) && a_lvl_q) begin
                            state_d = S_END;
                            ecnt_d  = '0;
                        end else begin
                            err_framing_d = 1'b1;
                            state_d       = S_ABORT;
                        end
                    end
                end else begin
                    if (b_fall_q) begin
                        sample_en  = 1'b1;
                        sample_bit = a_lvl_q;
                    end else if (a_fall_q) begin
                        err_framing_d = 1'b1;
                        state_d       = S_ABORT;
                    end
                end
            end
            S_END: begin
                if (!enable) begin
                    state_d = S_ABORT;
                end else if (tmo_hit) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_ABORT;
                end else if (b_rise_q) begin
                    if ((ecnt_q == 2'd2) && hold_vld_q) begin
                        // Out register busy: ABORT performs the tlast flush without an error.
                        if (out_free) begin
                            tvalid_d   = 1'b1;
                            tdata_d    = hold_q;
                            tlast_d    = 1'b1;
                            hold_vld_d = 1'b0;
                            state_d    = S_IDLE;
                        end else begin
                            state_d = S_ABORT;
                        end
                    end else begin
                        err_framing_d = 1'b1;
                        state_d       = S_ABORT;
                    end
                end else if (a_fall_q && !b_lvl_q && (ecnt_q != 2'd3)) begin
                    ecnt_d = ecnt_q + 2'd1;
                end
            end
            S_ABORT: begin
                if (!hold_vld_q) begin
                    state_d = S_IDLE;
                end else if (out_free) begin
                    tvalid_d   = 1'b1;
                    tdata_d    = hold_q;
                    tlast_d    = 1'b1;
                    hold_vld_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bit capture; the completed byte pushes any held byte out with tlast=0.
        if (sample_en) begin
            shift_d   = {shift_q[BYTE_W-2:0], sample_bit};
            bitcnt_d  = bitcnt_q + 3'd1;
            phase_b_d = ~phase_b_q;
            if (bitcnt_q == 3'd7) begin
                if (hold_vld_q && !out_free) begin
                    err_overflow_d = 1'b1;
                    state_d        = S_ABORT;
                end else begin
                    if (hold_vld_q) begin
                        tvalid_d = 1'b1;
                        tdata_d  = hold_q;
                        tlast_d  = 1'b0;
                    end
                    hold_d     = {shift_q[BYTE_W-2:0], sample_bit};
                    hold_vld_d = 1'b1;
                end
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q        <= S_IDLE;
            pcnt_q         <= '0;
            ecnt_q         <= '0;
            bitcnt_q       <= '0;
            phase_b_q      <= 1'b0;
            shift_q        <= '0;
            tmo_q          <= '0;
            hold_q         <= '0;
            hold_vld_q     <= 1'b0;
            tvalid_q       <= 1'b0;
            tdata_q        <= '0;
            tlast_q        <= 1'b0;
            rcv_q          <= 1'b0;
            err_framing_q  <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pcnt_q         <= pcnt_d;
            ecnt_q         <= ecnt_d;
            bitcnt_q       <= bitcnt_d;
            phase_b_q      <= phase_b_d;
            shift_q        <= shift_d;
            tmo_q          <= tmo_d;
            hold_q         <= hold_d;
            hold_vld_q     <= hold_vld_d;
            tvalid_q       <= tvalid_d;
            tdata_q        <= tdata_d;
            tlast_q        <= tlast_d;
            rcv_q          <= (state_d != S_IDLE);
            err_framing_q  <= err_framing_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tstrb  = 1'b1;
    assign m_axis_tkeep  = 1'b1;
    assign receiving     = rcv_q;
    assign err_framing   = err_framing_q;
    assign err_timeout   = err_timeout_q;
    assign err_overflow  = err_overflow_q;

endmodule
